// File: rtl/vip_pkg.sv
// Shared definitions for the vip_core convolution datapath.
// Holds the window MAC state encodings, the default window size,
// the accumulator width derivation and the saturation bounds.
package vip_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_DRAIN = 3'd2,
    ST_FINAL = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  localparam int WIN_DEFAULT = 25;

  // Product width plus enough guard bits to sum 'win' worst-case products.
  function automatic int acc_width(input int data_w, input int wgt_w, input int win);
    return data_w + wgt_w + $clog2(win);
  endfunction

  // Largest positive value representable in a signed w-bit word.
  function automatic longint sat_max(input int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  // Most negative value representable in a signed w-bit word.
  function automatic longint sat_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/window_mac_pipe.sv
// Purpose: registered signed multiply followed by a running accumulator.
// Latency: product one cycle after ld, accumulated the cycle after that.
// Backpressure: none; the caller gates ld and holds state via clr.
module window_mac_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int WGT_WIDTH  = 16,
  parameter int ACC_WIDTH  = 53
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         ld,
  input  logic [DATA_WIDTH-1:0]        data,
  input  logic [WGT_WIDTH-1:0]         wgt,
  output logic signed [ACC_WIDTH-1:0]  acc
);

  localparam int PROD_W = DATA_WIDTH + WGT_WIDTH;

  logic signed [PROD_W-1:0] prod_reg;
  logic                     prod_vld;

  // Capture one product per loaded word; an idle cycle marks the slot empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_reg <= '0;
      prod_vld <= 1'b0;
    end else if (clr) begin
      prod_reg <= '0;
      prod_vld <= 1'b0;
    end else begin
      prod_vld <= ld;
      if (ld) begin
        prod_reg <= PROD_W'($signed(data)) * PROD_W'($signed(wgt));
      end
    end
  end

  // Fold each valid product into the sign-extended running sum.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (prod_vld) begin
      acc <= acc + ACC_WIDTH'(prod_reg);
    end
  end

endmodule

// File: rtl/conv_window_mac.sv
// Purpose: drain one WIN-word window, weighted sum + bias, shift, ReLU, saturate.
// Latency: result valid WIN+2 cycles after the first pop; +1 per empty cycle.
// Backpressure: stalls on fifo_empty; holds result and pops nothing until out_ready.
module conv_window_mac
  import vip_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int WGT_WIDTH  = 16,
  parameter int WIN        = WIN_DEFAULT,
  parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, WGT_WIDTH, WIN),
  parameter int SHIFT      = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  relu_en,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_req,
  input  logic                  wgt_we,
  input  logic [$clog2(WIN):0]  wgt_addr,
  input  logic [DATA_WIDTH-1:0] wgt_data,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy
);

  localparam int TAP_W  = $clog2(WIN);
  localparam int ADDR_W = TAP_W + 1;
  localparam int SUM_W  = ACC_WIDTH + 1;

  localparam logic [TAP_W-1:0]         LAST_TAP  = TAP_W'(WIN - 1);
  localparam logic [ADDR_W-1:0]        BIAS_ADDR = ADDR_W'(WIN);
  localparam logic signed [SUM_W-1:0]  SAT_HI    = SUM_W'(sat_max(DATA_WIDTH));
  localparam logic signed [SUM_W-1:0]  SAT_LO    = SUM_W'(sat_min(DATA_WIDTH));

  state_t                      state;
  state_t                      state_nxt;
  logic [TAP_W-1:0]            tap_cnt;
  logic [WGT_WIDTH-1:0]        w [WIN];
  logic [DATA_WIDTH-1:0]       bias;
  logic                        pop;
  logic                        clr;
  logic [WGT_WIDTH-1:0]        cur_wgt;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [SUM_W-1:0]     sum;
  logic signed [SUM_W-1:0]     res;
  logic [DATA_WIDTH-1:0]       sat_val;

  assign pop         = (state == ST_READ) && !fifo_empty;
  assign fifo_rd_req = pop;
  assign busy        = (state != ST_IDLE);
  assign cur_wgt     = w[tap_cnt];

  window_mac_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .WGT_WIDTH  (WGT_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_pipe (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .ld    (pop),
    .data  (fifo_data),
    .wgt   (cur_wgt),
    .acc   (acc)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state; clr fires whenever a fresh window is about to start.
  always_comb begin
    state_nxt = state;
    clr       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (en) begin
          clr       = 1'b1;
          state_nxt = ST_READ;
        end
      end
      ST_READ: begin
        if (pop && (tap_cnt == LAST_TAP)) begin
          state_nxt = ST_DRAIN;
        end
      end
      ST_DRAIN: state_nxt = ST_FINAL;
      ST_FINAL: state_nxt = ST_OUT;
      ST_OUT: begin
        if (out_ready) begin
          clr       = 1'b1;
          state_nxt = en ? ST_READ : ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Tap index advances per pop and wraps after the last tap so it stays in range.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tap_cnt <= '0;
    end else if (clr) begin
      tap_cnt <= '0;
    end else if (pop) begin
      tap_cnt <= (tap_cnt == LAST_TAP) ? '0 : tap_cnt + 1'b1;
    end
  end

  // Weight/bias bank; only writable between windows so a window never sees mixed weights.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIN; i++) begin
        w[i] <= '0;
      end
      bias <= '0;
    end else if ((state == ST_IDLE) && wgt_we) begin
      if (wgt_addr < BIAS_ADDR) begin
        w[wgt_addr[TAP_W-1:0]] <= wgt_data[WGT_WIDTH-1:0];
      end else if (wgt_addr == BIAS_ADDR) begin
        bias <= wgt_data;
      end
    end
  end

  // Bias add, arithmetic rescale, optional ReLU, then clamp to the output range.
  always_comb begin
    sum = SUM_W'(acc) + SUM_W'($signed(bias));
    res = sum >>> SHIFT;
    if (relu_en && res[SUM_W-1]) begin
      res = '0;
    end
    sat_val = res[DATA_WIDTH-1:0];
    if (res > SAT_HI) begin
      sat_val = SAT_HI[DATA_WIDTH-1:0];
    end else if (res < SAT_LO) begin
      sat_val = SAT_LO[DATA_WIDTH-1:0];
    end
  end

  // Result register: loaded in FINAL, held through OUT until the handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (state == ST_FINAL) begin
      out_data  <= sat_val;
      out_valid <= 1'b1;
    end else if ((state == ST_OUT) && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_conv_window_mac.sv
// Directed bench for conv_window_mac with a behavioural FIFO source.
// Expected results are hand-computed constants per window.
// Downstream ready is held high except for the result-hold scenario.
module tb_conv_window_mac;

  localparam int DW  = 32;
  localparam int WIN = 25;
  localparam int AW  = $clog2(WIN) + 1;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          en = 1'b0;
  logic          relu_en = 1'b0;
  logic [DW-1:0] fifo_data;
  logic          fifo_empty;
  logic          fifo_rd_req;
  logic          wgt_we = 1'b0;
  logic [AW-1:0] wgt_addr = '0;
  logic [DW-1:0] wgt_data = '0;
  logic [DW-1:0] out_data;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic          busy;

  logic [DW-1:0] mem [256];
  int            rd_ptr = 0;
  int            wr_ptr = 0;
  logic          stall = 1'b0;
  int            cyc = 0;
  int            bad_pops = 0;
  int            n_tests = 0;
  int            n_fail = 0;

  always #5 clk = ~clk;

  conv_window_mac #(.SHIFT(0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .relu_en     (relu_en),
    .fifo_data   (fifo_data),
    .fifo_empty  (fifo_empty),
    .fifo_rd_req (fifo_rd_req),
    .wgt_we      (wgt_we),
    .wgt_addr    (wgt_addr),
    .wgt_data    (wgt_data),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .busy        (busy)
  );

  assign fifo_data  = mem[rd_ptr & 255];
  assign fifo_empty = (rd_ptr == wr_ptr) || stall;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (fifo_rd_req) rd_ptr <= rd_ptr + 1;
  always @(negedge clk) if (fifo_rd_req && fifo_empty) bad_pops <= bad_pops + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] d);
    mem[wr_ptr & 255] = d;
    wr_ptr++;
  endtask

  task automatic push_ramp();
    for (int i = 1; i <= WIN; i++) push(32'(i));
  endtask

  task automatic push_const(input logic [31:0] d);
    for (int i = 0; i < WIN; i++) push(d);
  endtask

  task automatic wr_wgt(input int a, input logic [31:0] d);
    @(negedge clk);
    wgt_we   = 1'b1;
    wgt_addr = AW'(a);
    wgt_data = d;
    @(negedge clk);
    wgt_we   = 1'b0;
  endtask

  task automatic set_wgts(input logic [31:0] d, input int n);
    for (int i = 0; i < n; i++) wr_wgt(i, d);
  endtask

  task automatic wait_pop(output int t, input string tag);
    int k = 0;
    do begin @(negedge clk); k++; end while (!fifo_rd_req && k < 100);
    check(tag, {31'd0, fifo_rd_req}, 32'd1);
    t = cyc;
  endtask

  task automatic wait_valid(output int t, input string tag);
    int k = 0;
    do begin @(negedge clk); k++; end while (!out_valid && k < 200);
    check(tag, {31'd0, out_valid}, 32'd1);
    t = cyc;
  endtask

  task automatic wait_idle(input string tag);
    int k = 0;
    while (busy && k < 200) begin @(negedge clk); k++; end
    check(tag, {31'd0, busy}, 32'd0);
  endtask

  task automatic skip_pops(input int n);
    int seen = 1;
    int k = 0;
    while (seen < n && k < 100) begin
      @(negedge clk);
      k++;
      if (fifo_rd_req) seen++;
    end
  endtask

  // One full window: start, optional 3-cycle empty gap after stall_after pops, check result/latency.
  task automatic run_window(input string tag, input logic [31:0] exp, input int stall_after);
    int t0, t1;
    @(negedge clk);
    en = 1'b1;
    wait_pop(t0, {tag, "_start"});
    en = 1'b0;
    if (stall_after > 0) begin
      skip_pops(stall_after);
      @(posedge clk); #1 stall = 1'b1;
      repeat (3) @(posedge clk);
      #1 stall = 1'b0;
    end
    wait_valid(t1, {tag, "_valid"});
    check({tag, "_data"}, out_data, exp);
    check({tag, "_lat"}, t1 - t0, WIN + 2 + ((stall_after > 0) ? 3 : 0));
    wait_idle({tag, "_idle"});
  endtask

  initial begin
    int t0, t1, unstable, pops;
    logic [31:0] held;

    #1 rst_n = 1'b0;
    push_ramp();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", out_data, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rd_req", {31'd0, fifo_rd_req}, 32'd0);

    // Plain ramp: 1+2+...+25 = 325.
    set_wgts(32'd1, WIN);
    run_window("ramp", 32'd325, 0);

    // All -1 data: sum -25, clamped to 0 by ReLU, else 0xFFFFFFE7.
    relu_en = 1'b1;
    push_const(32'hFFFF_FFFF);
    run_window("relu_neg", 32'd0, 0);
    relu_en = 1'b0;
    push_const(32'hFFFF_FFFF);
    run_window("neg_sum", 32'hFFFF_FFE7, 0);

    // Saturation at both ends of the output range.
    set_wgts(32'h0000_7FFF, WIN);
    push_const(32'h7FFF_FFFF);
    run_window("sat_hi", 32'h7FFF_FFFF, 0);
    push_const(32'h8000_0000);
    run_window("sat_lo", 32'h8000_0000, 0);

    // Three empty cycles after the 10th tap: same sum, three cycles later.
    set_wgts(32'd1, WIN);
    push_ramp();
    run_window("stall", 32'd325, 10);
    check("stall_no_empty_pop", bad_pops, 0);

    // Bias 100; a write to address 32 is out of range and must not alias tap 0.
    wr_wgt(WIN, 32'd100);
    wr_wgt(32, 32'd7);
    push_ramp();
    run_window("bias", 32'd425, 0);

    // Result held 5 cycles with the next window already queued.
    out_ready = 1'b0;
    push_ramp();
    push_const(32'd1);
    @(negedge clk);
    en = 1'b1;
    wait_pop(t0, "hold_start");
    wait_valid(t1, "hold_valid");
    check("hold_data", out_data, 32'd425);
    check("hold_lat", t1 - t0, WIN + 2);
    held     = out_data;
    unstable = 0;
    pops     = 0;
    wgt_we   = 1'b1;
    wgt_addr = '0;
    wgt_data = 32'd50;
    repeat (5) begin
      @(negedge clk);
      wgt_we = 1'b0;
      if (!out_valid || out_data !== held) unstable++;
      if (fifo_rd_req) pops++;
    end
    check("hold_stable", unstable, 0);
    check("hold_no_pops", pops, 0);
    out_ready = 1'b1;
    @(negedge clk);
    check("hold_next_pop", {31'd0, fifo_rd_req}, 32'd1);
    check("hold_valid_drop", {31'd0, out_valid}, 32'd0);
    en = 1'b0;
    wait_valid(t1, "locked_valid");
    check("wgt_locked", out_data, 32'd125);
    wait_idle("locked_idle");

    // Async reset at tap 12, then a clean window with fresh weights.
    push_ramp();
    @(negedge clk);
    en = 1'b1;
    wait_pop(t0, "abort_start");
    en = 1'b0;
    skip_pops(12);
    #2 rst_n = 1'b0;
    #1;
    check("abort_out_valid", {31'd0, out_valid}, 32'd0);
    check("abort_out_data", out_data, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_rd_req", {31'd0, fifo_rd_req}, 32'd0);
    @(negedge clk);
    rst_n  = 1'b1;
    wr_ptr = rd_ptr;
    // Only taps 0..19 rewritten; taps 20..24 and bias must read back as reset zeros: 1+..+20 = 210.
    set_wgts(32'd1, 20);
    push_ramp();
    run_window("post_rst", 32'd210, 0);

    check("no_empty_pop", bad_pops, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
